// File: rtl/iob_layer_sequencer.sv
// Map-buffer sequencer: ECG load phase, then per-layer read streaming and write counting
// for layers 1..LAST_LAYER. The layer index bit0 selects the ping-pong bank.
module iob_layer_sequencer #(
   parameter int ADDR_W     = 13,
   parameter int LAST_LAYER = 8
) (
   input  logic              clk_cal,
   input  logic              rst_cal_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] ecg_len,
   input  logic [ADDR_W-1:0] rd_len,
   input  logic [ADDR_W-1:0] wr_len,
   input  logic              wr_vld,
   input  logic              rd_rdy,
   output logic [3:0]        nn_layer_cnt,
   output logic              SPI_start,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              Mem_Data_Ivld,
   output logic              layer_start,
   output logic              busy,
   output logic              done,
   output logic              err_ovf,
   output logic [2:0]        state_dbg
);

   // Handshake: a write beat is one cycle of wr_vld addressed by the same-cycle wr_addr;
   // a read is requested by rd_rdy in cycle n and presented as Mem_Data_Ivld/rd_addr in n+1.

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_INIT = 3'd2,
      S_RUN  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [3:0]        LAST_IDX = 4'(LAST_LAYER);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t            state;
   state_t            state_nxt;

   logic [ADDR_W-1:0] wr_cnt;
   logic [ADDR_W-1:0] rd_cnt;
   logic [ADDR_W-1:0] ecg_len_q;
   logic [ADDR_W-1:0] rd_len_q;
   logic [ADDR_W-1:0] wr_len_q;

   logic [ADDR_W-1:0] wr_lim;
   logic              wr_open;
   logic              wr_take;
   logic              wr_ovf;
   logic              rd_take;
   logic              start_ok;
   logic              load_end;
   logic              run_end;
   logic              last_layer;

   // The write limit depends on the phase: ECG length while loading, layer length while running.
   assign wr_lim     = (state == S_LOAD) ? ecg_len_q : wr_len_q;
   assign wr_open    = ((state == S_LOAD) || (state == S_RUN)) && (wr_cnt < wr_lim);
   assign wr_take    = wr_vld && wr_open;
   assign wr_ovf     = wr_vld && !wr_open;
   assign rd_take    = (state == S_RUN) && rd_rdy && (rd_cnt < rd_len_q);
   assign start_ok   = (state == S_IDLE) && start;
   assign load_end   = (state == S_LOAD) && (wr_cnt == ecg_len_q);
   assign last_layer = (nn_layer_cnt == LAST_IDX);
   // A read still in flight keeps the layer open until it has been presented.
   assign run_end    = (state == S_RUN) && (rd_cnt == rd_len_q) &&
                       (wr_cnt == wr_len_q) && !Mem_Data_Ivld;

   assign wr_addr    = wr_cnt;
   assign state_dbg  = state;

   always_ff @(posedge clk_cal or negedge rst_cal_n) begin
      if (!rst_cal_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      SPI_start   = 1'b0;
      layer_start = 1'b0;
      done        = 1'b0;
      busy        = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            SPI_start = 1'b1;
            if (load_end) begin
               state_nxt = S_INIT;
            end
         end
         S_INIT: begin
            layer_start = 1'b1;
            state_nxt   = S_RUN;
         end
         S_RUN: begin
            if (run_end) begin
               state_nxt = last_layer ? S_DONE : S_INIT;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_cal or negedge rst_cal_n) begin
      if (!rst_cal_n) begin
         nn_layer_cnt <= 4'd0;
         ecg_len_q    <= '0;
         rd_len_q     <= '0;
         wr_len_q     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  ecg_len_q    <= ecg_len;
                  nn_layer_cnt <= 4'd0;
               end
            end
            S_LOAD: begin
               if (load_end) begin
                  nn_layer_cnt <= 4'd1;
               end
            end
            S_INIT: begin
               rd_len_q <= rd_len;
               wr_len_q <= wr_len;
            end
            S_RUN: begin
               if (run_end && !last_layer) begin
                  nn_layer_cnt <= nn_layer_cnt + 4'd1;
               end
            end
            S_DONE: begin
               nn_layer_cnt <= 4'd0;
            end
            default: begin
               nn_layer_cnt <= 4'd0;
            end
         endcase
      end
   end

   // Counters clear on accepted start and on every INIT; overflowing beats leave wr_cnt alone.
   always_ff @(posedge clk_cal or negedge rst_cal_n) begin
      if (!rst_cal_n) begin
         wr_cnt <= '0;
      end else if (start_ok || (state == S_INIT)) begin
         wr_cnt <= '0;
      end else if (wr_take) begin
         wr_cnt <= wr_cnt + ADDR_ONE;
      end
   end

   always_ff @(posedge clk_cal or negedge rst_cal_n) begin
      if (!rst_cal_n) begin
         rd_cnt        <= '0;
         rd_addr       <= '0;
         Mem_Data_Ivld <= 1'b0;
      end else begin
         Mem_Data_Ivld <= rd_take;
         if (start_ok || (state == S_INIT)) begin
            rd_cnt <= '0;
         end else if (rd_take) begin
            rd_cnt  <= rd_cnt + ADDR_ONE;
            rd_addr <= rd_cnt;
         end
      end
   end

   always_ff @(posedge clk_cal or negedge rst_cal_n) begin
      if (!rst_cal_n) begin
         err_ovf <= 1'b0;
      end else if (start_ok) begin
         err_ovf <= 1'b0;
      end else if (wr_ovf) begin
         err_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_iob_layer_sequencer.sv
// Directed bench for iob_layer_sequencer: driver pushes expected read/write addresses,
// layer indices and done pulses into queues; a negedge monitor pops and compares them.
module tb_iob_layer_sequencer;

   localparam int ADDR_W = 13;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_INIT = 3'd2;
   localparam logic [2:0] ST_RUN  = 3'd3;

   logic              clk_cal;
   logic              rst_cal_n;
   logic              start;
   logic [ADDR_W-1:0] ecg_len;
   logic [ADDR_W-1:0] rd_len;
   logic [ADDR_W-1:0] wr_len;
   logic              wr_vld;
   logic              rd_rdy;
   logic [3:0]        nn_layer_cnt;
   logic              SPI_start;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic              Mem_Data_Ivld;
   logic              layer_start;
   logic              busy;
   logic              done;
   logic              err_ovf;
   logic [2:0]        state_dbg;

   // Per-layer configuration table, indexed by the DUT's layer index like the real config ROM.
   logic [ADDR_W-1:0] cfg_rd [0:15];
   logic [ADDR_W-1:0] cfg_wr [0:15];
   assign rd_len = cfg_rd[nn_layer_cnt];
   assign wr_len = cfg_wr[nn_layer_cnt];

   logic [ADDR_W-1:0] rd_exp_q[$];
   logic [ADDR_W-1:0] wr_exp_q[$];
   logic [3:0]        lay_exp_q[$];
   logic [3:0]        done_exp_q[$];

   int checks = 0;
   int errors = 0;

   iob_layer_sequencer #(.ADDR_W(ADDR_W), .LAST_LAYER(8)) dut (
      .clk_cal       (clk_cal),
      .rst_cal_n     (rst_cal_n),
      .start         (start),
      .ecg_len       (ecg_len),
      .rd_len        (rd_len),
      .wr_len        (wr_len),
      .wr_vld        (wr_vld),
      .rd_rdy        (rd_rdy),
      .nn_layer_cnt  (nn_layer_cnt),
      .SPI_start     (SPI_start),
      .wr_addr       (wr_addr),
      .rd_addr       (rd_addr),
      .Mem_Data_Ivld (Mem_Data_Ivld),
      .layer_start   (layer_start),
      .busy          (busy),
      .done          (done),
      .err_ovf       (err_ovf),
      .state_dbg     (state_dbg)
   );

   initial begin
      clk_cal = 1'b0;
      forever #5 clk_cal = ~clk_cal;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_cal);
      #1;
   endtask

   task automatic chk_quiet(input string name);
      chk(name, {nn_layer_cnt, SPI_start, wr_addr, rd_addr, Mem_Data_Ivld,
                 layer_start, busy, done, err_ovf, state_dbg}, 64'd0);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string name);
      int n;
      n = 0;
      while ((state_dbg != s) && (n < budget)) begin
         tick();
         n++;
      end
      chk(name, state_dbg, s);
   endtask

   task automatic cfg_clear();
      for (int i = 0; i < 16; i++) begin
         cfg_rd[i] = '0;
         cfg_wr[i] = '0;
      end
   endtask

   task automatic expect_full_run();
      for (int l = 1; l <= 8; l++) lay_exp_q.push_back(4'(l));
      done_exp_q.push_back(4'd8);
   endtask

   task automatic pulse_start(input logic [ADDR_W-1:0] len);
      ecg_len = len;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   // Monitor: every presented output event must match the head of its expected queue.
   always @(negedge clk_cal) begin
      if (rst_cal_n) begin
         if (Mem_Data_Ivld) begin
            if (rd_exp_q.size() == 0) chk("rd_unexpected", rd_addr, 64'hffff_ffff);
            else chk("rd_addr", rd_addr, rd_exp_q.pop_front());
         end
         if (wr_vld) begin
            if (wr_exp_q.size() == 0) chk("wr_unexpected", wr_addr, 64'hffff_ffff);
            else chk("wr_addr", wr_addr, wr_exp_q.pop_front());
         end
         if (layer_start) begin
            if (lay_exp_q.size() == 0) chk("layer_unexpected", nn_layer_cnt, 64'hff);
            else chk("layer_idx", nn_layer_cnt, lay_exp_q.pop_front());
         end
         if (done) begin
            if (done_exp_q.size() == 0) chk("done_unexpected", nn_layer_cnt, 64'hff);
            else chk("done_layer", nn_layer_cnt, done_exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [3:0] exp_cnt;
      rst_cal_n = 1'b0;
      start     = 1'b0;
      ecg_len   = '0;
      wr_vld    = 1'b0;
      rd_rdy    = 1'b0;
      cfg_clear();
      tick();
      tick();
      chk_quiet("reset_outputs");
      rst_cal_n = 1'b1;
      tick();

      // Run A: ECG load of 4, streaming layer, backpressure layer, overflow layer, zero layers.
      cfg_rd[1] = 13'd5; cfg_wr[1] = 13'd3;
      cfg_rd[2] = 13'd4; cfg_wr[2] = 13'd0;
      cfg_rd[3] = 13'd0; cfg_wr[3] = 13'd2;
      expect_full_run();
      pulse_start(13'd4);
      chk("load_spi_start", SPI_start, 1'b1);
      chk("load_busy", busy, 1'b1);
      chk("load_state", state_dbg, ST_LOAD);
      for (int i = 0; i < 4; i++) begin
         wr_vld = 1'b1;
         wr_exp_q.push_back(ADDR_W'(i));
         chk("ecg_spi_start", SPI_start, 1'b1);
         tick();
      end
      wr_vld = 1'b0;
      wait_state(ST_INIT, 5, "layer1_init");
      chk("layer1_idx", nn_layer_cnt, 4'd1);

      rd_rdy = 1'b1;
      for (int i = 0; i < 5; i++) rd_exp_q.push_back(ADDR_W'(i));
      tick();
      for (int k = 0; k < 7; k++) begin
         wr_vld = (k < 3);
         if (k < 3) wr_exp_q.push_back(ADDR_W'(k));
         chk("stream_ivld", Mem_Data_Ivld, (k >= 1) && (k <= 5));
         tick();
      end
      wr_vld = 1'b0;
      chk("layer2_init", state_dbg, ST_INIT);
      chk("layer2_idx", nn_layer_cnt, 4'd2);

      for (int i = 0; i < 4; i++) rd_exp_q.push_back(ADDR_W'(i));
      tick();
      for (int k = 0; k < 9; k++) begin
         rd_rdy = (k < 8) && (k % 2 == 0);
         chk("bp_ivld", Mem_Data_Ivld, k % 2 == 1);
         tick();
      end
      rd_rdy = 1'b0;
      chk("layer3_init", state_dbg, ST_INIT);
      chk("layer3_idx", nn_layer_cnt, 4'd3);

      tick();
      for (int k = 0; k < 3; k++) begin
         wr_vld = 1'b1;
         wr_exp_q.push_back(ADDR_W'((k < 2) ? k : 2));
         if (k == 0) chk("ovf_clear_before", err_ovf, 1'b0);
         tick();
      end
      wr_vld = 1'b0;
      chk("ovf_flag", err_ovf, 1'b1);
      chk("ovf_layer_done", nn_layer_cnt, 4'd4);
      wait_state(ST_IDLE, 40, "runa_idle");
      chk("runa_layer_zero", nn_layer_cnt, 4'd0);
      chk("ovf_sticky", err_ovf, 1'b1);

      // Run B: all lengths zero, exact cycle timeline, start mid-run must be ignored.
      cfg_clear();
      expect_full_run();
      pulse_start(13'd0);
      for (int c = 1; c <= 19; c++) begin
         if (c == 1) exp_cnt = 4'd0;
         else if (c <= 17) exp_cnt = 4'(c / 2);
         else if (c == 18) exp_cnt = 4'd8;
         else exp_cnt = 4'd0;
         chk("zb_layer", nn_layer_cnt, exp_cnt);
         chk("zb_done", done, c == 18);
         chk("zb_busy", busy, c <= 18);
         if (c == 1) chk("zb_ovf_cleared", err_ovf, 1'b0);
         start   = (c == 6);
         ecg_len = (c == 6) ? 13'd5 : 13'd0;
         tick();
      end
      start = 1'b0;
      chk("zb_idle", state_dbg, ST_IDLE);

      // Run C: reset while RUN at layer 3, then a clean restart.
      cfg_rd[3] = 13'd3;
      cfg_wr[3] = 13'd2;
      for (int l = 1; l <= 3; l++) lay_exp_q.push_back(4'(l));
      pulse_start(13'd0);
      begin
         int n;
         n = 0;
         while (!((state_dbg == ST_RUN) && (nn_layer_cnt == 4'd3)) && (n < 20)) begin
            tick();
            n++;
         end
      end
      chk("rc_run_l3", {nn_layer_cnt, state_dbg}, {4'd3, ST_RUN});
      wr_vld = 1'b1;
      rd_rdy = 1'b1;
      wr_exp_q.push_back(13'd0);
      rd_exp_q.push_back(13'd0);
      tick();
      wr_vld = 1'b0;
      rd_rdy = 1'b0;
      tick();
      chk("rc_wr_addr_mid", wr_addr, 13'd1);
      rst_cal_n = 1'b0;
      #2;
      chk_quiet("rc_reset_outputs");
      tick();
      rst_cal_n = 1'b1;
      tick();
      cfg_clear();
      expect_full_run();
      pulse_start(13'd0);
      chk("rc_restart_load", {SPI_start, busy, state_dbg}, {1'b1, 1'b1, ST_LOAD});
      wait_state(ST_IDLE, 40, "rc_idle");
      chk("rc_layer_zero", nn_layer_cnt, 4'd0);

      tick();
      chk("rd_q_empty", rd_exp_q.size(), 0);
      chk("wr_q_empty", wr_exp_q.size(), 0);
      chk("lay_q_empty", lay_exp_q.size(), 0);
      chk("done_q_empty", done_exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iob_layer_sequencer.md
# iob_layer_sequencer

Controller that sequences the ping-pong map buffer across one full inference.
- Owns `nn_layer_cnt`, `SPI_start`, `wr_addr`, `rd_addr` and `Mem_Data_Ivld` for the map buffer.
- Runs the ECG load phase first, then each layer in turn: streams the layer's input reads and counts the layer's output writes.
- Advances the layer index only when both streams have completed.
- Sits between the top-level control (start/config) and the map buffer / Input_Regfile.

## Interface
Parameters:
- `ADDR_W`, default 13: map buffer address width.
- `LAST_LAYER`, default 8: index of the final layer; layers run 1..`LAST_LAYER`.

Ports:
- `clk_cal` in 1: clock.
- `rst_cal_n` in 1: reset, asynchronous, active-low.
- `start` in 1: inference start pulse. Ignored while `busy`.
- `ecg_len` in `ADDR_W`: number of ECG words to load. Sampled on accepted `start`.
- `rd_len` in `ADDR_W`: reads for the current layer, from the layer config indexed by `nn_layer_cnt`. Sampled in INIT.
- `wr_len` in `ADDR_W`: writes expected for the current layer. Sampled in INIT.
- `wr_vld` in 1: one write beat from ECG, R&P or FC (the selected source).
- `rd_rdy` in 1: Input_Regfile can accept one read beat.
- `nn_layer_cnt` out 4: layer index; bit0 selects the ping-pong bank.
- `SPI_start` out 1: ECG load phase active.
- `wr_addr` out `ADDR_W`: write address, combinational from the write counter.
- `rd_addr` out `ADDR_W`: read address, registered.
- `Mem_Data_Ivld` out 1: read strobe, registered, aligned with `rd_addr`.
- `layer_start` out 1: one-cycle pulse in INIT.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at inference end.
- `err_ovf` out 1: sticky error flag; cleared by reset or accepted `start`.

## Operation
- **States:** IDLE, LOAD, INIT, RUN, DONE.
- **Registers:** write counter `wr_cnt`, read counter `rd_cnt`, and latched lengths `ecg_len_q`, `rd_len_q`, `wr_len_q`.
- **IDLE:**
  - `nn_layer_cnt`=0.
  - On `start`: latch `ecg_len`, clear counters and `err_ovf`, go to LOAD.
- **LOAD:**
  - `SPI_start`=1 and `nn_layer_cnt`=0, so ECG words are written into bank ram1.
  - Each `wr_vld` writes at `wr_addr`=`wr_cnt`, then `wr_cnt`+1.
  - Exit when `wr_cnt`==`ecg_len_q`, including immediately when `ecg_len`=0.
  - On exit: `nn_layer_cnt`<=1, go to INIT.
- **INIT** (one cycle):
  - `layer_start`=1.
  - Latch `rd_len`/`wr_len`, clear both counters, go to RUN.
- **RUN:**
  - Read side: if `rd_rdy` and `rd_cnt`<`rd_len_q`, then next cycle `Mem_Data_Ivld`=1 with `rd_addr`=`rd_cnt`, and `rd_cnt`+1. Otherwise `Mem_Data_Ivld`=0.
  - Write side: each `wr_vld` with `wr_cnt`<`wr_len_q` writes at `wr_addr`=`wr_cnt`, then `wr_cnt`+1.
  - Reads and writes proceed concurrently and independently (opposite banks).
- **RUN exit** when `rd_cnt`==`rd_len_q`, `wr_cnt`==`wr_len_q` and `Mem_Data_Ivld`==0:
  - If `nn_layer_cnt`==`LAST_LAYER`: go to DONE.
  - Otherwise `nn_layer_cnt`+1 and go to INIT.
- **DONE:** `done`=1 for one cycle, then IDLE; `nn_layer_cnt`<=0 on entering IDLE.
- **Write overflow:** `wr_vld` when `wr_cnt`==length, or in IDLE/INIT/DONE.
  - The beat is not counted and `wr_cnt` holds.
  - `err_ovf`<=1.
- **Zero-length layers:** `rd_len`=0 issues no reads; `wr_len`=0 expects no writes. A layer with both zero spends exactly INIT + 1 RUN cycle.
- **Counter width:** counters are `ADDR_W` bits. Lengths must be ≤ 2^`ADDR_W`−1, so counters never wrap.

## Timing
- **Reset values:** state IDLE, every output 0, `err_ovf`=0.
- **Reset mid-operation:** immediate return to IDLE with the reset values above. No partial state is retained.
- **Start latency:**
  - `start` at cycle 0 → `SPI_start`=1 and `busy`=1 at cycle 1.
  - `wr_addr`=0 valid from cycle 1.
- **Write path:** `wr_addr` is valid in the same cycle as the `wr_vld` it addresses; the counter updates at the following edge.
- **Read path:** `rd_rdy` at cycle n → `Mem_Data_Ivld`/`rd_addr` at cycle n+1. The buffer returns data at n+2.
- **Streaming rate:** sustained `rd_rdy` gives one read per cycle with no bubbles.
- **Layer change:** after the final beat, the RUN exit condition holds within 1 cycle; INIT follows 1 cycle later. `nn_layer_cnt` changes at the INIT entry edge.
- **Simultaneous last read and last write:** exit is taken once, with no double increment.
- **`start` during `busy`:** ignored, no effect.

## Test plan
- **ECG load:** `ecg_len`=4, `wr_vld` ×4.
  - Expect `wr_addr` 0,1,2,3 with `SPI_start`=1.
  - Then `nn_layer_cnt`=1 and `layer_start` pulse.
- **Layer streaming:** `rd_len`=5, `wr_len`=3, `rd_rdy` constant.
  - Expect `rd_addr` 0..4 on 5 consecutive `Mem_Data_Ivld` cycles.
  - After the 3rd write, expect advance to layer 2.
- **Backpressure:** `rd_rdy` toggling 1,0,1,0.
  - Expect `Mem_Data_Ivld` to follow one cycle later.
  - Expect no skipped or repeated addresses.
- **Overflow:** `wr_len`=2, 3 `wr_vld` beats.
  - Expect `err_ovf`=1 and `wr_cnt` held at 2.
  - Layer still completes.
- **Full run with zero lengths:** all lengths 0.
  - Expect `nn_layer_cnt` 1..8, then a `done` pulse and `nn_layer_cnt`=0.
  - Expect `start` during the run to be ignored.
- **Reset mid-RUN:** assert `rst_cal_n`=0 during RUN at layer 3.
  - Expect all outputs 0 and IDLE.
  - A new `start` restarts from LOAD.
